cc_completer: RTL

- Generates Completion-with-Data TLPs on the PCIe IP Completer Completion (CC) AXI-Stream interface in response to BAR0 memory-read requests decoded from the CQ interface.
- Captures one read descriptor, issues a single register read, and waits for the data or a timeout.
- Emits a single-beat completion and holds it until the IP core accepts it.
- Covers the Logic -> PCIe_IP_core -> Host return path of MMIO reads.

---
 rtl/pcie_cc_pkg.sv | 40 ++++
 rtl/cc_desc_pack.sv | 51 +++++
 rtl/cc_completer.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/pcie_cc_pkg.sv
// Shared definitions for the PCIe completer paths: FSM states, CC descriptor
// field offsets, completion status codes and the CQ request type decode.
package pcie_cc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_SEND    = 2'd2
  } cc_state_t;

  // CQ request type for a memory read
  localparam logic [3:0] CQ_TYPE_MEM_RD = 4'b0000;

  // Completion status codes
  localparam logic [2:0] CPL_SC = 3'b000;
  localparam logic [2:0] CPL_UR = 3'b001;
  localparam logic [2:0] CPL_CA = 3'b100;

  // CC descriptor bit offsets within tdata
  localparam int OFF_LOWER_ADDR = 0;
  localparam int OFF_BYTE_CNT   = 16;
  localparam int OFF_DW_CNT     = 32;
  localparam int OFF_STATUS     = 43;
  localparam int OFF_REQ_ID     = 48;
  localparam int OFF_TAG        = 64;
  localparam int OFF_TC         = 89;
  localparam int OFF_DW3        = 96;
  localparam int OFF_DW4        = 128;

  // A zero DW count is treated as a single DW
  function automatic logic [10:0] cc_dw_eff(input logic [10:0] dw);
    return (dw == 11'd0) ? 11'd1 : dw;
  endfunction

  // Byte count field derived from the requested DW count
  function automatic logic [12:0] cc_byte_count(input logic [10:0] dw);
    return {cc_dw_eff(dw), 2'b00};
  endfunction

endpackage

// File: rtl/cc_desc_pack.sv
// Combinational packer: builds the single-beat CC completion (descriptor plus
// payload) and its DW keep mask from the registered request fields.
module cc_desc_pack
  import pcie_cc_pkg::*;
#(
  parameter int DATA_WIDTH = 256
) (
  input  logic [6:0]              lower_addr,
  input  logic [15:0]             requester_id,
  input  logic [7:0]              tag,
  input  logic [2:0]              tc,
  input  logic [10:0]             dword_count,
  input  logic [63:0]             rd_data,
  output logic [DATA_WIDTH-1:0]   tdata,
  output logic [DATA_WIDTH/32-1:0] tkeep
);

  logic [10:0] dw_eff;

  assign dw_eff = cc_dw_eff(dword_count);

  // Assemble descriptor and payload; unused bits stay zero
  always_comb begin
    tdata = '0;
    tkeep = '0;
    tdata[OFF_LOWER_ADDR +: 7] = lower_addr;
    tdata[OFF_BYTE_CNT   +: 13] = cc_byte_count(dword_count);
    tdata[OFF_REQ_ID     +: 16] = requester_id;
    tdata[OFF_TAG        +: 8]  = tag;
    tdata[OFF_TC         +: 3]  = tc;
    if (dw_eff == 11'd1) begin
      // Single DW: pick the half of the QW the byte address points at
      tdata[OFF_DW_CNT +: 11] = 11'd1;
      tdata[OFF_STATUS +: 3]  = CPL_SC;
      tdata[OFF_DW3    +: 32] = lower_addr[2] ? rd_data[63:32] : rd_data[31:0];
      tkeep[3:0] = 4'hF;
    end else if (dw_eff == 11'd2) begin
      tdata[OFF_DW_CNT +: 11] = 11'd2;
      tdata[OFF_STATUS +: 3]  = CPL_SC;
      tdata[OFF_DW3    +: 32] = rd_data[31:0];
      tdata[OFF_DW4    +: 32] = rd_data[63:32];
      tkeep[4:0] = 5'h1F;
    end else begin
      // Reads wider than a QW are aborted: descriptor only, no payload
      tdata[OFF_DW_CNT +: 11] = 11'd0;
      tdata[OFF_STATUS +: 3]  = CPL_CA;
      tkeep[2:0] = 3'h7;
    end
  end

endmodule

// File: rtl/cc_completer.sv
// BAR0 MMIO read completer: captures a CQ memory-read descriptor, issues one
// register read, waits for data (or times out) and returns a single-beat
// Completion-with-Data on the CC AXI-Stream interface.
module cc_completer
  import pcie_cc_pkg::*;
#(
  parameter int DATA_WIDTH = 256,
  parameter int BAR0_SIZE  = 16,
  parameter int RD_TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cq_valid,
  input  logic [3:0]               cq_type,
  input  logic [BAR0_SIZE-1:0]     cq_reg_addr,
  input  logic [15:0]              cq_requester_id,
  input  logic [7:0]               cq_tag,
  input  logic [2:0]               cq_tc,
  input  logic [6:0]               cq_lower_addr,
  input  logic [10:0]              cq_dword_count,
  output logic                     rd_req,
  output logic [BAR0_SIZE-1:0]     rd_addr,
  input  logic                     rd_data_valid,
  input  logic [63:0]              rd_data,
  output logic [DATA_WIDTH-1:0]    s_axis_cc_tdata,
  output logic [DATA_WIDTH/32-1:0] s_axis_cc_tkeep,
  output logic                     s_axis_cc_tlast,
  output logic [32:0]              s_axis_cc_tuser,
  output logic                     s_axis_cc_tvalid,
  input  logic                     s_axis_cc_tready,
  output logic                     busy,
  output logic [15:0]              drop_cnt
);

  localparam logic [15:0] TO_LIMIT = 16'(RD_TIMEOUT);

  cc_state_t state, state_nxt;

  logic        rd_hit;
  logic        capture;
  logic        drop;
  logic        timeout_hit;
  logic        data_done;
  logic        handshake;
  logic [15:0] to_cnt;

  logic [6:0]  lower_q;
  logic [15:0] rid_q;
  logic [7:0]  tag_q;
  logic [2:0]  tc_q;
  logic [10:0] dwc_q;
  logic [63:0] rdata_q;

  logic [DATA_WIDTH-1:0]    pack_tdata;
  logic [DATA_WIDTH/32-1:0] pack_tkeep;

  // Low address bits are dropped by QW alignment of the register read
  logic unused_addr_bits;
  assign unused_addr_bits = ^cq_reg_addr[2:0];

  assign rd_hit      = cq_valid && (cq_type == CQ_TYPE_MEM_RD);
  assign capture     = rd_hit && (state == ST_IDLE);
  assign drop        = rd_hit && (state != ST_IDLE);
  // Data arriving on the timeout cycle takes priority over the timeout
  assign timeout_hit = (state == ST_RD_WAIT) && !rd_data_valid && (to_cnt == TO_LIMIT);
  assign data_done   = (state == ST_RD_WAIT) && rd_data_valid;
  assign handshake   = s_axis_cc_tvalid && s_axis_cc_tready;

  assign busy            = (state != ST_IDLE);
  assign s_axis_cc_tlast = s_axis_cc_tvalid;
  assign s_axis_cc_tuser = '0;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:    if (capture) state_nxt = ST_RD_WAIT;
      ST_RD_WAIT: if (data_done || timeout_hit) state_nxt = ST_SEND;
      ST_SEND:    if (handshake) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Register read strobe and QW-aligned address, issued the cycle after capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_req  <= 1'b0;
      rd_addr <= '0;
    end else begin
      rd_req <= capture;
      if (capture) rd_addr <= {cq_reg_addr[BAR0_SIZE-1:3], 3'b000};
    end
  end

  // Read wait counter, cleared whenever not waiting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= '0;
    end else if (state == ST_RD_WAIT) begin
      if (!rd_data_valid && (to_cnt != TO_LIMIT)) to_cnt <= to_cnt + 16'd1;
    end else begin
      to_cnt <= '0;
    end
  end

  // Descriptor fields captured with the request
  always_ff @(posedge clk) begin
    if (capture) begin
      lower_q <= cq_lower_addr;
      rid_q   <= cq_requester_id;
      tag_q   <= cq_tag;
      tc_q    <= cq_tc;
      dwc_q   <= cq_dword_count;
    end
  end

  // Read data, or all-ones when the register never answered
  always_ff @(posedge clk) begin
    if (data_done)        rdata_q <= rd_data;
    else if (timeout_hit) rdata_q <= 64'hFFFF_FFFF_FFFF_FFFF;
  end

  cc_desc_pack #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_pack (
    .lower_addr   (lower_q),
    .requester_id (rid_q),
    .tag          (tag_q),
    .tc           (tc_q),
    .dword_count  (dwc_q),
    .rd_data      (rdata_q),
    .tdata        (pack_tdata),
    .tkeep        (pack_tkeep)
  );

  // Output beat: loaded on the first SEND cycle, held until accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_axis_cc_tvalid <= 1'b0;
      s_axis_cc_tdata  <= '0;
      s_axis_cc_tkeep  <= '0;
    end else if ((state == ST_SEND) && !s_axis_cc_tvalid) begin
      s_axis_cc_tvalid <= 1'b1;
      s_axis_cc_tdata  <= pack_tdata;
      s_axis_cc_tkeep  <= pack_tkeep;
    end else if (handshake) begin
      s_axis_cc_tvalid <= 1'b0;
    end
  end

  // Saturating count of reads that arrived while busy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           drop_cnt <= '0;
    else if (drop && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
  end

endmodule
